// File: rtl/alu_exec_stage_if.sv
// Handshake bundle between ALU decode, the execute stage and writeback.
// The master side is the upstream producer / downstream consumer pair that
// drives operands and out_ready; the slave side is the execute stage itself.
interface alu_exec_stage_if #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5
);
  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       in_alu_op;
  logic [XLEN-1:0]  in_a;
  logic [XLEN-1:0]  in_b;
  logic [TAG_W-1:0] in_rd;
  logic             out_valid;
  logic             out_ready;
  logic [XLEN-1:0]  out_result;
  logic [TAG_W-1:0] out_rd;
  logic             out_illegal;

  modport master (
    output flush, in_valid, in_alu_op, in_a, in_b, in_rd, out_ready,
    input  in_ready, out_valid, out_result, out_rd, out_illegal
  );

  modport slave (
    input  flush, in_valid, in_alu_op, in_a, in_b, in_rd, out_ready,
    output in_ready, out_valid, out_result, out_rd, out_illegal
  );
endinterface

// File: rtl/alu_exec_stage.sv
// RV32I integer ALU execute stage with a 2-entry (main + skid) output buffer.
// Latency: op accepted at edge N is presented on out_* right after edge N.
// Backpressure: in_ready = !skid_valid, a pure state decode; outputs hold while stalled.
//
// Ports:
//   clk, reset_n   clock and asynchronous active-low reset
//   io (slave)     flush, in_valid/in_ready + in_alu_op/in_a/in_b/in_rd,
//                  out_valid/out_ready + out_result/out_rd/out_illegal
module alu_exec_stage #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5
) (
  input  logic          clk,
  input  logic          reset_n,
  alu_exec_stage_if.slave io
);

  localparam int SHW = $clog2(XLEN);

  // ALUop encodings shared with the decoder
  localparam logic [3:0] ALU_ADD    = 4'd0;
  localparam logic [3:0] ALU_SUB    = 4'd1;
  localparam logic [3:0] ALU_AND    = 4'd2;
  localparam logic [3:0] ALU_OR     = 4'd3;
  localparam logic [3:0] ALU_XOR    = 4'd4;
  localparam logic [3:0] ALU_SLT    = 4'd5;
  localparam logic [3:0] ALU_SLTU   = 4'd6;
  localparam logic [3:0] ALU_SLL    = 4'd7;
  localparam logic [3:0] ALU_SRA    = 4'd8;
  localparam logic [3:0] ALU_SRL    = 4'd9;
  localparam logic [3:0] ALU_COPY_B = 4'd10;

  // Encoding is {skid_valid, main_valid}
  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    ONE   = 2'b01,
    FULL  = 2'b11
  } state_t;

  state_t state, state_nxt;

  logic [XLEN-1:0]  alu_res;
  logic             alu_ill;
  logic [SHW-1:0]   shamt;

  logic [XLEN-1:0]  main_result, skid_result;
  logic [TAG_W-1:0] main_rd, skid_rd;
  logic             main_illegal, skid_illegal;

  logic main_valid, in_ready_int, accept, out_xfer;
  logic load_main_new, load_main_skid, load_skid_new;

  // ---------------- ALU ----------------
  assign shamt = io.in_b[SHW-1:0];

  always_comb begin
    alu_res = '0;
    alu_ill = 1'b0;
    case (io.in_alu_op)
      ALU_ADD:    alu_res = io.in_a + io.in_b;
      ALU_SUB:    alu_res = io.in_a - io.in_b;
      ALU_AND:    alu_res = io.in_a & io.in_b;
      ALU_OR:     alu_res = io.in_a | io.in_b;
      ALU_XOR:    alu_res = io.in_a ^ io.in_b;
      ALU_SLT:    alu_res[0] = ($signed(io.in_a) < $signed(io.in_b));
      ALU_SLTU:   alu_res[0] = (io.in_a < io.in_b);
      ALU_SLL:    alu_res = io.in_a << shamt;
      ALU_SRA:    alu_res = $unsigned($signed(io.in_a) >>> shamt);
      ALU_SRL:    alu_res = io.in_a >> shamt;
      ALU_COPY_B: alu_res = io.in_b;
      // ALU_XXX and unused codes still transfer, flagged as illegal
      default:    alu_ill = 1'b1;
    endcase
  end

  // ---------------- handshake control ----------------
  assign main_valid   = (state != EMPTY);
  assign in_ready_int = (state != FULL);
  assign accept       = io.in_valid & in_ready_int;
  assign out_xfer     = main_valid & io.out_ready;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= EMPTY;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt      = state;
    load_main_new  = 1'b0;
    load_main_skid = 1'b0;
    load_skid_new  = 1'b0;
    if (io.flush) begin
      // Squash everything; an out transfer this cycle was already seen
      // downstream, and any op handshaked now is dropped.
      state_nxt = EMPTY;
    end else begin
      case (state)
        EMPTY: begin
          if (accept) begin
            state_nxt     = ONE;
            load_main_new = 1'b1;
          end
        end
        ONE: begin
          if (accept && out_xfer) begin
            load_main_new = 1'b1;
          end else if (accept) begin
            // Main is stalled: park the new op so main stays stable
            state_nxt     = FULL;
            load_skid_new = 1'b1;
          end else if (out_xfer) begin
            state_nxt = EMPTY;
          end
        end
        FULL: begin
          if (out_xfer) begin
            state_nxt      = ONE;
            load_main_skid = 1'b1;
          end
        end
        default: state_nxt = EMPTY;
      endcase
    end
  end

  // ---------------- data registers ----------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      main_result  <= '0;
      main_rd      <= '0;
      main_illegal <= 1'b0;
      skid_result  <= '0;
      skid_rd      <= '0;
      skid_illegal <= 1'b0;
    end else begin
      if (load_main_new) begin
        main_result  <= alu_res;
        main_rd      <= io.in_rd;
        main_illegal <= alu_ill;
      end else if (load_main_skid) begin
        main_result  <= skid_result;
        main_rd      <= skid_rd;
        main_illegal <= skid_illegal;
      end
      if (load_skid_new) begin
        skid_result  <= alu_res;
        skid_rd      <= io.in_rd;
        skid_illegal <= alu_ill;
      end
    end
  end

  assign io.in_ready    = in_ready_int;
  assign io.out_valid   = main_valid;
  assign io.out_result  = main_result;
  assign io.out_rd      = main_rd;
  assign io.out_illegal = main_illegal;

endmodule
